// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - MSB-first word serializer with bit-period divider.
// Define RESULT_SERIALIZER_PARITY_EN to append an even-parity bit period to each frame.
module result_serializer #(
  parameter int WIDTH = 32,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             ser_strobe,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef RESULT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             done_pend;
  logic             period_end;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic             par_bit;
`endif

  assign period_end = (div_cnt == DIV_LAST);
  assign in_ready   = (state == IDLE) && ena;

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    ser_frame  = (state != IDLE);
    ser_strobe = (state != IDLE) && ena && (div_cnt == '0);
    done       = done_pend && ena;
    ser_data   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && ena) state_next = SHIFT;
      end
      SHIFT: begin
        ser_data = shreg[WIDTH-1];
        if (ena && period_end && (bit_cnt == '0)) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_data = par_bit;
        if (ena && period_end) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Everything, including the pending done pulse, is frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      done_pend <= 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (ena) begin
      state     <= state_next;
      done_pend <= (state != IDLE) && (state_next == IDLE);
      if (state == IDLE) begin
        if (in_valid) begin
          shreg   <= in_data;
          bit_cnt <= BIT_LAST;
          div_cnt <= '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
          par_bit <= ^in_data;
`endif
        end
      end else if (period_end) begin
        div_cnt <= '0;
        if ((state == SHIFT) && (bit_cnt != '0)) begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule
